// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - CTR-mode sequencer driving a combinational AES-128 core
// Holds {nonce, ctr} on the core for a settle window, then XORs the captured keystream into the stream.
module aes_ctr_stream #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NONCE_W       = 96
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NONCE_W-1:0]   nonce_in,
    input  logic [127-NONCE_W:0] ctr_init,
    output logic [127:0]         aes_plain,
    input  logic [127:0]         aes_cipher,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [127:0]         s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [127:0]         m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 ctr_wrap
);
    localparam int          CTR_W       = 128 - NONCE_W;
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GEN, ACCEPT, DRAIN} state_t;

    state_t             state_q;
    logic [3:0]         settle_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [127:0]       ks_q;
    logic [127:0]       aes_plain_q;
    logic [127:0]       m_data_q;
    logic               m_last_q;
    logic               m_valid_q;
    logic               s_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               ctr_wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            ks_q        <= '0;
            aes_plain_q <= '0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        nonce_q     <= nonce_in;
                        ctr_q       <= ctr_init;
                        aes_plain_q <= {nonce_in, ctr_init};
                        settle_q    <= SETTLE_INIT;
                        ctr_wrap_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= GEN;
                    end
                end
                GEN: begin
                    // aes_plain is frozen here so the core output is stable when sampled
                    if (settle_q == 4'd0) begin
                        ks_q      <= aes_cipher;
                        s_ready_q <= 1'b1;
                        state_q   <= ACCEPT;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                ACCEPT: begin
                    if (s_valid) begin
                        m_data_q  <= s_data ^ ks_q;
                        m_last_q  <= s_last;
                        m_valid_q <= 1'b1;
                        ctr_q     <= ctr_q + 1'b1;
                        if (&ctr_q) ctr_wrap_q <= 1'b1;
                        s_ready_q <= 1'b0;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (m_last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            aes_plain_q <= {nonce_q, ctr_q};
                            settle_q    <= SETTLE_INIT;
                            state_q     <= GEN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign aes_plain = aes_plain_q;
    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ctr_wrap  = ctr_wrap_q;
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - randomized self-checking bench for aes_ctr_stream with a stub XOR core
module tb_aes_ctr_stream;
    localparam int           SETTLE = 4;
    localparam logic [127:0] PAD    = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [95:0]  nonce_in = '0;
    logic [31:0]  ctr_init = '0;
    logic [127:0] aes_plain;
    logic [127:0] aes_cipher;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         ctr_wrap;

    int n_vec = 0;
    int n_err = 0;

    aes_ctr_stream #(.SETTLE_CYCLES(SETTLE), .NONCE_W(96)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nonce_in(nonce_in), .ctr_init(ctr_init),
        .aes_plain(aes_plain), .aes_cipher(aes_cipher),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
    );

    // Stand-in for the AES core: a fixed XOR pad keeps the keystream predictable
    assign aes_cipher = aes_plain ^ PAD;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_msg(input logic [95:0] nonce, input logic [31:0] c0, input int nwords,
                           input int bp_min, input int bp_max, input bit poke_start, input bit abort);
        logic [127:0] d, exp_plain, exp_out;
        logic         last;
        logic         wrap_exp;
        int           lat, bp;
        wrap_exp = 1'b0;
        nonce_in = nonce;
        ctr_init = c0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
        check("wrap_cleared", 128'(ctr_wrap), 128'(0));
        for (int k = 0; k < nwords; k++) begin
            exp_plain = {nonce, c0 + 32'(k)};
            lat = 0;
            while (!s_ready && lat < 64) begin
                check("plain_gen", aes_plain, exp_plain);
                s_valid = 1'($urandom_range(0, 1));
                s_data  = rnd128();
                m_ready = 1'($urandom_range(0, 1));
                if (poke_start && k == 0 && lat == 1) begin
                    start    = 1'b1;
                    nonce_in = ~nonce;
                    ctr_init = ~c0;
                end else begin
                    start = 1'b0;
                end
                tick();
                lat++;
            end
            start = 1'b0;
            check("settle_latency", 128'(lat), 128'(SETTLE));
            check("plain_accept", aes_plain, exp_plain);
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("ready_hold", 128'(s_ready), 128'(1));
            end
            d       = rnd128();
            last    = (k == nwords - 1);
            exp_out = d ^ exp_plain ^ PAD;
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last;
            m_ready = 1'b0;
            tick();
            s_valid = 1'($urandom_range(0, 1));
            s_data  = rnd128();
            s_last  = 1'($urandom_range(0, 1));
            if (c0 + 32'(k) == 32'hFFFF_FFFF) wrap_exp = 1'b1;
            check("m_valid_set", 128'(m_valid), 128'(1));
            check("m_data", m_data, exp_out);
            check("m_last", 128'(m_last), 128'(last));
            check("ready_drop", 128'(s_ready), 128'(0));
            check("ctr_wrap", 128'(ctr_wrap), 128'(wrap_exp));
            if (abort) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_plain", aes_plain, 128'(0));
                check("rst_mdata", m_data, 128'(0));
                check("rst_ctl", {123'(0), m_valid, s_ready, busy, done, m_last}, 128'(0));
                check("rst_wrap", 128'(ctr_wrap), 128'(0));
                tick();
                rst_n   = 1'b1;
                s_valid = 1'b0;
                return;
            end
            bp = $urandom_range(bp_min, bp_max);
            repeat (bp) begin
                m_ready = 1'b0;
                tick();
                s_valid = 1'($urandom_range(0, 1));
                check("bp_valid", 128'(m_valid), 128'(1));
                check("bp_data", m_data, exp_out);
                check("bp_ready", 128'(s_ready), 128'(0));
                check("bp_plain", aes_plain, exp_plain);
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check("m_valid_clr", 128'(m_valid), 128'(0));
            check("done", 128'(done), 128'(last));
            check("busy", 128'(busy), 128'(!last));
        end
        s_valid = 1'b0;
        tick();
        check("done_pulse_end", 128'(done), 128'(0));
        check("wrap_sticky", 128'(ctr_wrap), 128'(wrap_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] nn;
        logic [31:0] cc;
        repeat (3) tick();
        check("reset_plain", aes_plain, 128'(0));
        check("reset_ctl", {122'(0), m_valid, s_ready, busy, done, m_last, ctr_wrap}, 128'(0));
        rst_n = 1'b1;
        tick();
        run_msg(96'h0, 32'h1, 1, 0, 0, 1'b0, 1'b0);
        run_msg(96'h0, 32'h10, 3, 0, 2, 1'b0, 1'b0);
        run_msg({$urandom, $urandom, $urandom}, 32'hFFFF_FFFF, 2, 0, 1, 1'b0, 1'b0);
        run_msg(96'h1234, 32'h5, 1, 0, 0, 1'b0, 1'b0);
        run_msg(96'hABC, 32'h77, 2, 10, 10, 1'b0, 1'b0);
        run_msg(96'hDEAD_BEEF, 32'h3, 2, 0, 1, 1'b1, 1'b0);
        nn = {$urandom, $urandom, $urandom};
        cc = $urandom;
        run_msg(nn, cc, 2, 0, 0, 1'b0, 1'b1);
        run_msg(nn, cc, 2, 0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            cc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
            run_msg({$urandom, $urandom, $urandom}, cc, $urandom_range(1, 4), 0, 3,
                    1'($urandom_range(0, 1)), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
